// File: rtl/uart_core.sv
// Parametrised full-duplex UART core with ready/valid byte interfaces and a one-deep RX holding register.
// Optional parity is enabled by defining UART_PARITY_EN.
module uart_core #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 115200,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ready,
  output logic                 txd,
  input  logic                 rxd,
  output logic                 rx_valid,
  output logic [DATA_BITS-1:0] rx_data,
  input  logic                 rx_ready,
  output logic                 rx_frame_err,
  output logic                 rx_parity_err,
  output logic                 rx_overrun,
  input  logic                 parity_odd
);

  if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data_bits
    $error("uart_core: DATA_BITS must be 5..8");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
    $error("uart_core: STOP_BITS must be 1 or 2");
  end
  if (OVERSAMPLE < 8 || (OVERSAMPLE & (OVERSAMPLE - 1)) != 0) begin : g_bad_oversample
    $error("uart_core: OVERSAMPLE must be a power of 2 and >= 8");
  end

  localparam int OS_PROD = BAUD * OVERSAMPLE;
  localparam int DIV_RAW = (CLK_FREQ + OS_PROD / 2) / OS_PROD;
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int OS_W    = $clog2(OVERSAMPLE);

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV - 1);
  localparam logic [OS_W-1:0]  OS_LAST   = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0]  OS_MID    = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [2:0]       DATA_LAST = 3'(DATA_BITS - 1);
  localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
`ifdef UART_PARITY_EN
    TX_PARITY,
`endif
    TX_STOP
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
`ifdef UART_PARITY_EN
    RX_PARITY,
`endif
    RX_STOP
  } rx_state_e;

  // Oversample tick generator, shared by both directions
  logic [DIV_W-1:0] div_q, div_d;
  logic             os_tick;

  always_comb begin
    os_tick = (div_q == DIV_LAST);
    div_d   = os_tick ? '0 : div_q + 1'b1;
  end

  // Transmitter
  tx_state_e            tx_state_q, tx_state_d;
  logic [OS_W-1:0]      tx_os_q, tx_os_d;
  logic [2:0]           tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
  logic                 txd_q, txd_d;
  logic                 tx_bit_end;
`ifdef UART_PARITY_EN
  logic                 tx_par_q, tx_par_d;
`endif

  always_comb begin
    tx_state_d = tx_state_q;
    tx_os_d    = tx_os_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    txd_d      = txd_q;
`ifdef UART_PARITY_EN
    tx_par_d   = tx_par_q;
`endif
    tx_bit_end = os_tick && (tx_os_q == OS_LAST);
    if (tx_state_q != TX_IDLE && os_tick) tx_os_d = tx_os_q + 1'b1;

    case (tx_state_q)
      TX_IDLE: begin
        txd_d = 1'b1;
        if (tx_valid) begin
          tx_state_d = TX_START;
          tx_shift_d = tx_data;
          tx_os_d    = '0;
          tx_bit_d   = '0;
          txd_d      = 1'b0;
`ifdef UART_PARITY_EN
          tx_par_d   = (^tx_data) ^ parity_odd;
`endif
        end
      end
      TX_START: begin
        if (tx_bit_end) begin
          tx_state_d = TX_DATA;
          txd_d      = tx_shift_q[0];
        end
      end
      TX_DATA: begin
        if (tx_bit_end) begin
          tx_shift_d = tx_shift_q >> 1;
          if (tx_bit_q == DATA_LAST) begin
            tx_bit_d = '0;
`ifdef UART_PARITY_EN
            tx_state_d = TX_PARITY;
            txd_d      = tx_par_q;
`else
            tx_state_d = TX_STOP;
            txd_d      = 1'b1;
`endif
          end else begin
            tx_bit_d = tx_bit_q + 1'b1;
            txd_d    = tx_shift_q[1];
          end
        end
      end
`ifdef UART_PARITY_EN
      TX_PARITY: begin
        if (tx_bit_end) begin
          tx_state_d = TX_STOP;
          tx_bit_d   = '0;
          txd_d      = 1'b1;
        end
      end
`endif
      TX_STOP: begin
        if (tx_bit_end) begin
          if (tx_bit_q == STOP_LAST) begin
            tx_state_d = TX_IDLE;
          end else begin
            tx_bit_d = tx_bit_q + 1'b1;
          end
          txd_d = 1'b1;
        end
      end
      default: begin
        tx_state_d = TX_IDLE;
        txd_d      = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q      <= '0;
      tx_state_q <= TX_IDLE;
      tx_os_q    <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      txd_q      <= 1'b1;
`ifdef UART_PARITY_EN
      tx_par_q   <= 1'b0;
`endif
    end else begin
      div_q      <= div_d;
      tx_state_q <= tx_state_d;
      tx_os_q    <= tx_os_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      txd_q      <= txd_d;
`ifdef UART_PARITY_EN
      tx_par_q   <= tx_par_d;
`endif
    end
  end

  assign tx_ready = (tx_state_q == TX_IDLE);
  assign txd      = txd_q;

  // Receiver
  logic                 rx_meta_q, rx_sync_q;
  rx_state_e            rx_state_q, rx_state_d;
  logic [OS_W-1:0]      rx_os_q, rx_os_d;
  logic [2:0]           rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
  logic                 rx_valid_q, rx_valid_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_ferr_q, rx_ferr_d;
  logic                 rx_ovr_q, rx_ovr_d;
  logic                 rx_sample, frame_done;
`ifdef UART_PARITY_EN
  logic                 rx_podd_q, rx_podd_d;
  logic                 rx_par_bad_q, rx_par_bad_d;
  logic                 rx_perr_q, rx_perr_d;
`else
  logic                 unused_parity_odd;
  assign unused_parity_odd = parity_odd;
`endif

  always_comb begin
    rx_state_d = rx_state_q;
    rx_os_d    = rx_os_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_valid_d = rx_valid_q;
    rx_data_d  = rx_data_q;
    rx_ferr_d  = rx_ferr_q;
    rx_ovr_d   = rx_ovr_q;
`ifdef UART_PARITY_EN
    rx_podd_d    = rx_podd_q;
    rx_par_bad_d = rx_par_bad_q;
    rx_perr_d    = rx_perr_q;
`endif
    frame_done = 1'b0;
    rx_sample  = os_tick && (rx_os_q == OS_LAST);
    if (rx_state_q != RX_IDLE && os_tick) rx_os_d = rx_os_q + 1'b1;

    case (rx_state_q)
      RX_IDLE: begin
        if (!rx_sync_q) begin
          rx_state_d = RX_START;
          rx_os_d    = '0;
`ifdef UART_PARITY_EN
          rx_podd_d  = parity_odd;
`endif
        end
      end
      RX_START: begin
        if (os_tick && rx_os_q == OS_MID) begin
          rx_os_d  = '0;
          rx_bit_d = '0;
          rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (rx_sample) begin
          rx_shift_d = {rx_sync_q, rx_shift_q[DATA_BITS-1:1]};
          if (rx_bit_q == DATA_LAST) begin
`ifdef UART_PARITY_EN
            rx_state_d = RX_PARITY;
`else
            rx_state_d = RX_STOP;
`endif
          end else begin
            rx_bit_d = rx_bit_q + 1'b1;
          end
        end
      end
`ifdef UART_PARITY_EN
      RX_PARITY: begin
        if (rx_sample) begin
          rx_par_bad_d = rx_sync_q ^ (^rx_shift_q) ^ rx_podd_q;
          rx_state_d   = RX_STOP;
        end
      end
`endif
      RX_STOP: begin
        if (rx_sample) begin
          frame_done = 1'b1;
          rx_state_d = RX_IDLE;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase

    // A completing frame only lands if the holding register is free or being drained
    if (frame_done) begin
      if (!rx_valid_q || rx_ready) begin
        rx_valid_d = 1'b1;
        rx_data_d  = rx_shift_q;
        rx_ferr_d  = ~rx_sync_q;
`ifdef UART_PARITY_EN
        rx_perr_d  = rx_par_bad_q;
`endif
        if (rx_valid_q) rx_ovr_d = 1'b0;
      end else begin
        rx_ovr_d = 1'b1;
      end
    end else if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
      rx_ovr_d   = 1'b0;
      rx_ferr_d  = 1'b0;
`ifdef UART_PARITY_EN
      rx_perr_d  = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_os_q    <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
      rx_ferr_q  <= 1'b0;
      rx_ovr_q   <= 1'b0;
`ifdef UART_PARITY_EN
      rx_podd_q    <= 1'b0;
      rx_par_bad_q <= 1'b0;
      rx_perr_q    <= 1'b0;
`endif
    end else begin
      rx_meta_q  <= rxd;
      rx_sync_q  <= rx_meta_q;
      rx_state_q <= rx_state_d;
      rx_os_q    <= rx_os_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_valid_q <= rx_valid_d;
      rx_data_q  <= rx_data_d;
      rx_ferr_q  <= rx_ferr_d;
      rx_ovr_q   <= rx_ovr_d;
`ifdef UART_PARITY_EN
      rx_podd_q    <= rx_podd_d;
      rx_par_bad_q <= rx_par_bad_d;
      rx_perr_q    <= rx_perr_d;
`endif
    end
  end

  assign rx_valid     = rx_valid_q;
  assign rx_data      = rx_data_q;
  assign rx_frame_err = rx_ferr_q;
  assign rx_overrun   = rx_ovr_q;
`ifdef UART_PARITY_EN
  assign rx_parity_err = rx_perr_q;
`else
  assign rx_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_core.sv
// Bench for uart_core at 16 clocks per bit; frames are modelled as plain bit lists.
module tb_uart_core;
  localparam int CLK_FREQ   = 1600000;
  localparam int BAUD       = 100000;
  localparam int DATA_BITS  = 8;
  localparam int STOP_BITS  = 1;
  localparam int OVERSAMPLE = 16;
  localparam int BIT_CLK    = 16;
`ifdef UART_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif
  localparam int FRAME_BITS = 1 + DATA_BITS + PAR_BITS + STOP_BITS;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = '0;
  logic       tx_ready;
  logic       txd;
  logic       rxd;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_ready = 1'b0;
  logic       rx_frame_err;
  logic       rx_parity_err;
  logic       rx_overrun;
  logic       parity_odd = 1'b0;
  logic       loop_en = 1'b0;
  logic       rxd_drv = 1'b1;

  int checks = 0;
  int passes = 0;

  typedef struct packed {
    logic [7:0] data;
    logic       ferr;
    logic       perr;
  } rx_rec_t;
  rx_rec_t got_q[$];

  always #5 clk = ~clk;
  assign rxd = loop_en ? txd : rxd_drv;

  uart_core #(
    .CLK_FREQ(CLK_FREQ),
    .BAUD(BAUD),
    .DATA_BITS(DATA_BITS),
    .STOP_BITS(STOP_BITS),
    .OVERSAMPLE(OVERSAMPLE)
  ) dut (
    .clk(clk),
    .reset(reset),
    .tx_valid(tx_valid),
    .tx_data(tx_data),
    .tx_ready(tx_ready),
    .txd(txd),
    .rxd(rxd),
    .rx_valid(rx_valid),
    .rx_data(rx_data),
    .rx_ready(rx_ready),
    .rx_frame_err(rx_frame_err),
    .rx_parity_err(rx_parity_err),
    .rx_overrun(rx_overrun),
    .parity_odd(parity_odd)
  );

  always @(negedge clk) begin
    if (rx_valid && rx_ready) got_q.push_back({rx_data, rx_frame_err, rx_parity_err});
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d passed=%0d", checks, passes);
    $fatal(1);
  end

  // Line level of bit k of a frame: start, LSB-first data, optional parity, stop
  function automatic logic frame_bit(input logic [7:0] d, input logic podd, input int k);
    if (k == 0) return 1'b0;
    if (k <= DATA_BITS) return d[k-1];
    if (PAR_BITS == 1 && k == DATA_BITS + 1) return (^d) ^ podd;
    return 1'b1;
  endfunction

  task automatic send_byte(input logic [7:0] d);
    int n = 0;
    @(negedge clk);
    while (tx_ready !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 1000) $display("FAIL tx_ready_wait: tx_ready=%b after %0d cycles, required 1", tx_ready, n);
    else passes++;
    tx_data  = d;
    tx_valid = 1'b1;
    @(posedge clk);
    #1 tx_valid = 1'b0;
  endtask

  task automatic drive_frame(input logic [7:0] d, input logic par_flip, input logic stop_val);
    logic b;
    for (int k = 0; k < FRAME_BITS; k++) begin
      b = frame_bit(d, parity_odd, k);
      if (PAR_BITS == 1 && k == DATA_BITS + 1) b = b ^ par_flip;
      if (k == FRAME_BITS - 1) b = stop_val;
      rxd_drv = b;
      repeat (BIT_CLK) @(posedge clk);
      #1;
    end
    rxd_drv = 1'b1;
  endtask

  task automatic consume;
    @(negedge clk);
    rx_ready = 1'b1;
    @(posedge clk);
    #1 rx_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_tx_frame(input logic [7:0] d);
    logic exp_b;
    send_byte(d);
    for (int k = 0; k < FRAME_BITS * BIT_CLK; k++) begin
      @(negedge clk);
      exp_b = frame_bit(d, parity_odd, k / BIT_CLK);
      checks++;
      if (txd !== exp_b) $display("FAIL tx_wave d=%h cycle %0d: txd=%b required %b", d, k, txd, exp_b);
      else passes++;
      checks++;
      if (tx_ready !== 1'b0) $display("FAIL tx_busy d=%h cycle %0d: tx_ready=%b required 0", d, k, tx_ready);
      else passes++;
    end
    @(negedge clk);
    checks++;
    if (tx_ready !== 1'b1 || txd !== 1'b1)
      $display("FAIL tx_idle d=%h: tx_ready=%b txd=%b required 1 1", d, tx_ready, txd);
    else passes++;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({txd, tx_ready, rx_valid, rx_data, rx_frame_err, rx_parity_err, rx_overrun} !== {1'b1, 1'b1, 1'b0, 8'h00, 3'b000})
      $display("FAIL reset_state: txd=%b tx_ready=%b rx_valid=%b rx_data=%h fe=%b pe=%b ovr=%b required 1 1 0 00 0 0 0",
               txd, tx_ready, rx_valid, rx_data, rx_frame_err, rx_parity_err, rx_overrun);
    else passes++;
    reset = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_tx;
    check_tx_frame(8'hA5);
    for (int i = 0; i < 3; i++) begin
      parity_odd = 1'($urandom_range(0, 1));
      check_tx_frame(8'($urandom));
    end
    parity_odd = 1'b0;
  endtask

  task automatic test_back_to_back;
    logic [7:0] exp_q[$];
    int n = 0;
    exp_q = '{8'h00, 8'hFF, 8'h55};
    for (int i = 0; i < 3; i++) exp_q.push_back(8'($urandom));
    got_q.delete();
    rx_ready = 1'b1;
    loop_en  = 1'b1;
    foreach (exp_q[i]) send_byte(exp_q[i]);
    while (got_q.size() < exp_q.size() && n < 1000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (got_q.size() != exp_q.size())
      $display("FAIL loop_count: got %0d frames, required %0d", got_q.size(), exp_q.size());
    else passes++;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== {exp_q[i], 2'b00})
        $display("FAIL loop_frame %0d: data=%h fe=%b pe=%b required %h 0 0", i, got_q[i].data, got_q[i].ferr, got_q[i].perr, exp_q[i]);
      else passes++;
    end
    repeat (40) @(negedge clk);
    loop_en = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_glitch;
    got_q.delete();
    rx_ready = 1'b1;
    @(posedge clk);
    #1 rxd_drv = 1'b0;
    repeat (4) @(posedge clk);
    #1 rxd_drv = 1'b1;
    repeat (40) @(negedge clk);
    checks++;
    if (got_q.size() != 0 || rx_valid !== 1'b0)
      $display("FAIL glitch: frames=%0d rx_valid=%b required 0 0", got_q.size(), rx_valid);
    else passes++;
    drive_frame(8'h3C, 1'b0, 1'b1);
    repeat (20) @(negedge clk);
    checks++;
    if (got_q.size() != 1 || got_q[0] !== {8'h3C, 2'b00})
      $display("FAIL glitch_next: frames=%0d first=%h required 1 frame 3C no errors", got_q.size(), got_q.size() ? got_q[0] : 10'h0);
    else passes++;
  endtask

  task automatic test_random_rx;
    logic [7:0] d;
    logic       stop_v, flip, exp_perr;
    rx_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      d        = 8'($urandom);
      stop_v   = ($urandom_range(0, 2) != 0);
      flip     = 1'($urandom_range(0, 1));
      exp_perr = (PAR_BITS == 1) ? flip : 1'b0;
      got_q.delete();
      drive_frame(d, flip, stop_v);
      repeat (20) @(negedge clk);
      checks++;
      if (got_q.size() != 1 || got_q[0] !== {d, ~stop_v, exp_perr})
        $display("FAIL rx_random %0d: frames=%0d first=%h required 1 frame %h fe=%b pe=%b",
                 i, got_q.size(), got_q.size() ? got_q[0] : 10'h0, d, ~stop_v, exp_perr);
      else passes++;
    end
  endtask

  task automatic test_overrun;
    rx_ready = 1'b0;
    drive_frame(8'h11, 1'b0, 1'b1);
    drive_frame(8'h22, 1'b0, 1'b1);
    repeat (20) @(negedge clk);
    checks++;
    if ({rx_valid, rx_data, rx_overrun, rx_frame_err} !== {1'b1, 8'h11, 1'b1, 1'b0})
      $display("FAIL overrun_hold: valid=%b data=%h ovr=%b fe=%b required 1 11 1 0", rx_valid, rx_data, rx_overrun, rx_frame_err);
    else passes++;
    consume();
    checks++;
    if (rx_valid !== 1'b0 || rx_overrun !== 1'b0)
      $display("FAIL overrun_clear: valid=%b ovr=%b required 0 0", rx_valid, rx_overrun);
    else passes++;
  endtask

  task automatic test_frame_err;
    rx_ready = 1'b0;
    drive_frame(8'h7E, 1'b0, 1'b0);
    repeat (20) @(negedge clk);
    checks++;
    if ({rx_valid, rx_data, rx_frame_err, rx_overrun} !== {1'b1, 8'h7E, 1'b1, 1'b0})
      $display("FAIL frame_err: valid=%b data=%h fe=%b ovr=%b required 1 7e 1 0", rx_valid, rx_data, rx_frame_err, rx_overrun);
    else passes++;
    consume();
    checks++;
    if (rx_valid !== 1'b0 || rx_frame_err !== 1'b0)
      $display("FAIL frame_err_clear: valid=%b fe=%b required 0 0", rx_valid, rx_frame_err);
    else passes++;
  endtask

  task automatic test_reset_mid;
    send_byte(8'($urandom));
    repeat (50) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (txd !== 1'b1 || tx_ready !== 1'b1)
      $display("FAIL reset_mid_tx: txd=%b tx_ready=%b required 1 1", txd, tx_ready);
    else passes++;
    reset = 1'b0;
    got_q.delete();
    rx_ready = 1'b1;
    rxd_drv  = 1'b0;
    repeat (80) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    rxd_drv = 1'b1;
    repeat (200) @(negedge clk);
    checks++;
    if (got_q.size() != 0 || rx_valid !== 1'b0 || txd !== 1'b1)
      $display("FAIL reset_mid_rx: frames=%0d rx_valid=%b txd=%b required 0 0 1", got_q.size(), rx_valid, txd);
    else passes++;
  endtask

`ifdef UART_PARITY_EN
  task automatic test_parity;
    parity_odd = 1'b0;
    send_byte(8'h07);
    repeat ((DATA_BITS + 1) * BIT_CLK + BIT_CLK / 2) @(negedge clk);
    checks++;
    if (txd !== 1'b1) $display("FAIL tx_parity_bit: txd=%b required 1", txd);
    else passes++;
    repeat (2 * BIT_CLK) @(negedge clk);
    rx_ready = 1'b0;
    drive_frame(8'h07, 1'b1, 1'b1);
    repeat (20) @(negedge clk);
    checks++;
    if ({rx_valid, rx_data, rx_parity_err, rx_frame_err} !== {1'b1, 8'h07, 1'b1, 1'b0})
      $display("FAIL rx_parity_err: valid=%b data=%h pe=%b fe=%b required 1 07 1 0", rx_valid, rx_data, rx_parity_err, rx_frame_err);
    else passes++;
    consume();
  endtask
`endif

  initial begin
    test_reset();
    test_tx();
    test_back_to_back();
    test_glitch();
    test_random_rx();
    test_overrun();
    test_frame_err();
    test_reset_mid();
`ifdef UART_PARITY_EN
    test_parity();
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
